// File: rtl/cache_control.sv
// Direct-mapped, write-back, write-allocate cache controller for an 8-set external data array.
// Tag/valid/dirty state is held here; the data array itself lives outside and is never cleared.
module cache_control #(
    parameter int unsigned width = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       mem_address,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [15:0]       mem_wdata,
    input  logic [1:0]        mem_byte_enable,
    output logic [15:0]       mem_rdata,
    output logic              mem_resp,
    output logic [15:0]       pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [width-1:0]  pmem_wdata,
    input  logic [width-1:0]  pmem_rdata,
    input  logic              pmem_resp,
    output logic [2:0]        set,
    output logic              data_write,
    output logic [width-1:0]  data_in,
    input  logic [width-1:0]  data_out
);

    localparam int unsigned TAG_W  = 9;
    localparam int unsigned SET_W  = 3;
    localparam int unsigned WORD_W = 3;
    localparam int unsigned SETS   = 8;
    localparam int unsigned BASE_W = 7;

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [TAG_W-1:0]  tags [SETS];
    logic [SETS-1:0]   valid;
    logic [SETS-1:0]   dirty;

    logic [SET_W-1:0]  idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WORD_W-1:0] word;
    logic [BASE_W-1:0] base;
    logic              hit;
    logic              req;
    logic              fill_done;
    logic              write_hit;
    logic [width-1:0]  merged;
    logic              unused_addr_lsb;

    assign idx       = mem_address[6:4];
    assign req_tag   = mem_address[15:7];
    assign word      = mem_address[3:1];
    assign base      = {word, 4'b0000};
    assign hit       = valid[idx] && (tags[idx] == req_tag);
    assign req       = mem_read || mem_write;
    assign fill_done = (state == FILL) && pmem_resp;
    assign write_hit = (state == CHECK) && mem_write && hit;
    assign set       = idx;
    assign unused_addr_lsb = mem_address[0];

    // Byte-lane merge of the write word into the current line
    always_comb begin
        merged = data_out;
        if (mem_byte_enable[0]) merged[base +: 8]            = mem_wdata[7:0];
        if (mem_byte_enable[1]) merged[BASE_W'(base + 8) +: 8] = mem_wdata[15:8];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= CHECK;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            CHECK: begin
                if (req && !hit)
                    state_next = (valid[idx] && dirty[idx]) ? WRITEBACK : FILL;
            end
            WRITEBACK: if (pmem_resp) state_next = FILL;
            FILL:      if (pmem_resp) state_next = CHECK;
            default:   state_next = CHECK;
        endcase
    end

    // Output logic; everything is held off while reset is asserted so an aborted fill writes nothing
    always_comb begin
        mem_resp     = 1'b0;
        mem_rdata    = data_out[base +: 16];
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = data_out;
        data_write   = 1'b0;
        data_in      = data_out;
        if (!reset) begin
            unique case (state)
                CHECK: begin
                    if (mem_write) begin
                        if (hit) begin
                            mem_resp   = 1'b1;
                            data_write = 1'b1;
                            data_in    = merged;
                        end
                    end else if (mem_read && hit) begin
                        mem_resp = 1'b1;
                    end
                end
                WRITEBACK: begin
                    pmem_write   = 1'b1;
                    pmem_address = {tags[idx], idx, 4'b0000};
                end
                FILL: begin
                    pmem_read    = 1'b1;
                    pmem_address = {mem_address[15:4], 4'b0000};
                    if (pmem_resp) begin
                        data_write = 1'b1;
                        data_in    = pmem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Valid/dirty bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill_done) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (write_hit) begin
            dirty[idx] <= 1'b1;
        end
    end

    // Tag store needs no reset; valid bits qualify it
    always_ff @(posedge clk) begin
        if (!reset && fill_done) tags[idx] <= req_tag;
    end

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: owns the data array and plays physical memory by hand.
module tb_cache_control;

    logic         clk;
    logic         reset;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_wdata;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic [2:0]   set;
    logic         data_write;
    logic [127:0] data_in;
    logic [127:0] data_out;

    logic [127:0] arr [8];

    int checks   = 0;
    int failures = 0;

    cache_control #(.width(128)) dut (
        .clk(clk), .reset(reset),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .set(set), .data_write(data_write), .data_in(data_in), .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign data_out = arr[set];
    always @(posedge clk) if (data_write) arr[set] <= data_in;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1ns after the edge, checks happen 3ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_resp"},  128'(mem_resp),     128'd0);
        chk({tag, "_pread"}, 128'(pmem_read),    128'd0);
        chk({tag, "_pwr"},   128'(pmem_write),   128'd0);
        chk({tag, "_dwr"},   128'(data_write),   128'd0);
        chk({tag, "_paddr"}, 128'(pmem_address), 128'd0);
    endtask

    logic [127:0] line1;
    logic [127:0] line1_w;
    logic [127:0] line1_ww;
    logic [127:0] line2;

    initial begin
        for (int i = 0; i < 8; i++) arr[i] = 128'd0;
        line1    = {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'hBEEF, 16'h0000};
        line1_w  = {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'hBE34, 16'h0000};
        line1_ww = {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'hA522, 16'hBE34, 16'h0000};
        line2    = {16'h8888, 16'h8888, 16'h8888, 16'h8888, 16'h8888, 16'h8888, 16'hCAFE, 16'h8888};
        reset = 1'b1; mem_address = 16'h0; mem_read = 1'b0; mem_write = 1'b0;
        mem_wdata = 16'h0; mem_byte_enable = 2'b00; pmem_rdata = 128'd0; pmem_resp = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #3 idle_outputs("rst");

        // Clean read miss on 0x0012 -> FILL of line 0x0010
        tick();
        mem_address = 16'h0012; mem_read = 1'b1;
        #3;
        chk("set_idx", 128'(set), 128'd1);
        idle_outputs("miss_chk");
        tick();
        #3;
        chk("fill_pread", 128'(pmem_read),    128'd1);
        chk("fill_addr",  128'(pmem_address), 128'h0010);
        chk("fill_pwr",   128'(pmem_write),   128'd0);
        chk("fill_hold_dwr", 128'(data_write), 128'd0);
        tick();
        pmem_rdata = line1; pmem_resp = 1'b1;
        #3;
        chk("fill_dwr", 128'(data_write), 128'd1);
        chk("fill_din", data_in, line1);
        chk("fill_noresp", 128'(mem_resp), 128'd0);
        tick();
        pmem_resp = 1'b0;
        #3;
        chk("post_fill_resp",  128'(mem_resp),  128'd1);
        chk("post_fill_rdata", 128'(mem_rdata), 128'hBEEF);
        chk("post_fill_pread", 128'(pmem_read), 128'd0);

        // Write hit, low byte only
        tick();
        mem_read = 1'b0; mem_write = 1'b1; mem_wdata = 16'h1234; mem_byte_enable = 2'b01;
        #3;
        chk("wr_resp", 128'(mem_resp),   128'd1);
        chk("wr_dwr",  128'(data_write), 128'd1);
        chk("wr_din",  data_in,          line1_w);
        tick();
        mem_write = 1'b0; mem_read = 1'b1;
        #3;
        chk("rd_after_wr", 128'(mem_rdata), 128'hBE34);
        chk("rd_after_wr_resp", 128'(mem_resp), 128'd1);
        chk("rd_hit_dwr", 128'(data_write), 128'd0);

        // Read and write together behave as a write (high byte of word 2)
        tick();
        mem_address = 16'h0014; mem_write = 1'b1; mem_wdata = 16'hA5FF; mem_byte_enable = 2'b10;
        #3;
        chk("rw_dwr", 128'(data_write), 128'd1);
        chk("rw_din", data_in, line1_ww);

        // Dirty conflict miss on 0x0092 -> WRITEBACK of 0x0010 then FILL of 0x0090
        tick();
        mem_write = 1'b0; mem_address = 16'h0092;
        #3 idle_outputs("dmiss_chk");
        tick();
        #3;
        chk("wb_pwr",   128'(pmem_write),   128'd1);
        chk("wb_pread", 128'(pmem_read),    128'd0);
        chk("wb_addr",  128'(pmem_address), 128'h0010);
        chk("wb_data",  pmem_wdata,         line1_ww);
        tick();
        pmem_resp = 1'b1;
        #3;
        chk("wb_resp_pwr", 128'(pmem_write), 128'd1);
        chk("wb_resp_dwr", 128'(data_write), 128'd0);
        tick();
        pmem_resp = 1'b0;
        #3;
        chk("wbf_pread", 128'(pmem_read),    128'd1);
        chk("wbf_pwr",   128'(pmem_write),   128'd0);
        chk("wbf_addr",  128'(pmem_address), 128'h0090);
        tick();
        pmem_rdata = line2; pmem_resp = 1'b1;
        #3 chk("wbf_din", data_in, line2);
        tick();
        pmem_resp = 1'b0;
        #3;
        chk("wbf_hit_resp",  128'(mem_resp),  128'd1);
        chk("wbf_hit_rdata", 128'(mem_rdata), 128'hCAFE);

        // Reset in the middle of a fill: no data write, tag not updated
        tick();
        mem_address = 16'h0012;
        #3 chk("abort_miss", 128'(mem_resp), 128'd0);
        tick();
        #3 chk("abort_pread", 128'(pmem_read), 128'd1);
        tick();
        reset = 1'b1; pmem_rdata = line1; pmem_resp = 1'b1;
        #3 chk("abort_dwr", 128'(data_write), 128'd0);
        tick();
        reset = 1'b0; pmem_resp = 1'b0;
        #3;
        chk("abort_pread_off", 128'(pmem_read), 128'd0);
        chk("abort_remiss",    128'(mem_resp),  128'd0);
        chk("abort_arr",       arr[1],          line2);
        tick();
        reset = 1'b1; mem_read = 1'b0;
        tick();
        reset = 1'b0;

        // pmem_resp while idle in CHECK is ignored
        #3 idle_outputs("idle0");
        tick();
        pmem_resp = 1'b1;
        #3 idle_outputs("idle_resp");
        tick();
        pmem_resp = 1'b0;
        #3 idle_outputs("idle_after");
        tick();
        mem_address = 16'h0092; mem_read = 1'b1;
        #3 chk("post_rst_miss", 128'(mem_resp), 128'd0);
        tick();
        #3;
        chk("post_rst_fill", 128'(pmem_read),    128'd1);
        chk("post_rst_addr", 128'(pmem_address), 128'h0090);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
